// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronizes four raw player buttons, debounces press and
// release, and reports one accepted one-hot play (or an invalid chord) per press.
module condicionador_botoes #(
    parameter int DEBOUNCE_CICLOS = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       invalida,
    output logic [1:0] db_estado
);

    localparam logic [1:0] OCIOSO       = 2'd0;
    localparam logic [1:0] FILTRA_PRESS = 2'd1;
    localparam logic [1:0] PRESSIONADO  = 2'd2;
    localparam logic [1:0] FILTRA_SOLTA = 2'd3;

    // Press is accepted on the edge that sees the count at N-1; release waits
    // for N further zero samples after the one that entered FILTRA_SOLTA.
    localparam logic [15:0] ALVO_PRESS = 16'(DEBOUNCE_CICLOS - 1);
    localparam logic [15:0] ALVO_SOLTA = 16'(DEBOUNCE_CICLOS);

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [15:0] incrementa_sat(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [3:0]  sync1_r;
    logic [3:0]  sync2_r;
    logic [3:0]  botoes_s;
    logic [1:0]  estado_r;
    logic [15:0] contador_r;
    logic [3:0]  amostra_r;
    logic [3:0]  jogada_r;
    logic        tem_jogada_r;
    logic        invalida_r;

    logic [1:0]  prox_estado_s;
    logic [15:0] prox_contador_s;
    logic [3:0]  prox_amostra_s;
    logic [3:0]  prox_jogada_s;
    logic        prox_tem_jogada_s;
    logic        prox_invalida_s;

    assign botoes_s = sync2_r;

    // Two-flop synchronizer for the asynchronous button inputs
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= botoes;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM next-state, counter and output-pulse decode
    always_comb begin
        prox_estado_s     = estado_r;
        prox_contador_s   = contador_r;
        prox_amostra_s    = amostra_r;
        prox_jogada_s     = jogada_r;
        prox_tem_jogada_s = 1'b0;
        prox_invalida_s   = 1'b0;
        case (estado_r)
            OCIOSO: begin
                if (habilita && (botoes_s != 4'b0000)) begin
                    prox_estado_s   = FILTRA_PRESS;
                    prox_contador_s = 16'd0;
                    prox_amostra_s  = botoes_s;
                end else begin
                    prox_estado_s   = OCIOSO;
                end
            end
            FILTRA_PRESS: begin
                if ((botoes_s != amostra_r) || !habilita) begin
                    prox_estado_s   = OCIOSO;
                    prox_contador_s = 16'd0;
                end else if (contador_r == ALVO_PRESS) begin
                    prox_estado_s   = PRESSIONADO;
                    prox_contador_s = 16'd0;
                    if (eh_one_hot(amostra_r)) begin
                        prox_jogada_s     = amostra_r;
                        prox_tem_jogada_s = 1'b1;
                    end else begin
                        prox_invalida_s   = 1'b1;
                    end
                end else begin
                    prox_contador_s = incrementa_sat(contador_r);
                end
            end
            PRESSIONADO: begin
                if (botoes_s == 4'b0000) begin
                    prox_estado_s   = FILTRA_SOLTA;
                    prox_contador_s = 16'd0;
                end else begin
                    prox_estado_s   = PRESSIONADO;
                end
            end
            FILTRA_SOLTA: begin
                if (botoes_s != 4'b0000) begin
                    prox_estado_s   = PRESSIONADO;
                    prox_contador_s = 16'd0;
                end else if (contador_r == ALVO_SOLTA) begin
                    prox_estado_s   = OCIOSO;
                    prox_contador_s = 16'd0;
                end else begin
                    prox_contador_s = incrementa_sat(contador_r);
                end
            end
            default: begin
                prox_estado_s   = OCIOSO;
                prox_contador_s = 16'd0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r     <= OCIOSO;
            contador_r   <= 16'd0;
            amostra_r    <= 4'b0000;
            jogada_r     <= 4'b0000;
            tem_jogada_r <= 1'b0;
            invalida_r   <= 1'b0;
        end else begin
            estado_r     <= prox_estado_s;
            contador_r   <= prox_contador_s;
            amostra_r    <= prox_amostra_s;
            jogada_r     <= prox_jogada_s;
            tem_jogada_r <= prox_tem_jogada_s;
            invalida_r   <= prox_invalida_s;
        end
    end

    assign jogada     = jogada_r;
    assign tem_jogada = tem_jogada_r;
    assign invalida   = invalida_r;
    assign db_estado  = estado_r;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes: directed latency scenarios plus
// randomized button/habilita traffic compared against a behavioural model.
module tb_condicionador_botoes;

    localparam int D = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       invalida;
    logic [1:0] db_estado;

    int checks = 0;
    int errors = 0;

    // Behavioural model: two-sample delay of the buttons, then play phases
    logic [3:0] m_s1 = 4'b0000;
    logic [3:0] m_s2 = 4'b0000;
    logic [3:0] m_alvo = 4'b0000;
    logic [3:0] m_jog = 4'b0000;
    logic [1:0] m_fase = 2'd0;
    int         m_run = 0;
    logic       m_tem = 1'b0;
    logic       m_inv = 1'b0;

    always #5 clock = ~clock;

    condicionador_botoes #(.DEBOUNCE_CICLOS(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .botoes     (botoes),
        .habilita   (habilita),
        .jogada     (jogada),
        .tem_jogada (tem_jogada),
        .invalida   (invalida),
        .db_estado  (db_estado)
    );

    // Advance the model by what the coming edge will see.
    task automatic model_step();
        logic [3:0] visto;
        visto = m_s2;
        m_tem = 1'b0;
        m_inv = 1'b0;
        if (reset) begin
            m_s1 = 4'b0000; m_s2 = 4'b0000; m_alvo = 4'b0000;
            m_jog = 4'b0000; m_fase = 2'd0; m_run = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = botoes;
            case (m_fase)
                2'd0: if (habilita && visto != 4'b0000) begin
                    m_fase = 2'd1; m_alvo = visto; m_run = 0;
                end
                2'd1: begin
                    if (visto != m_alvo || !habilita) begin
                        m_fase = 2'd0;
                    end else if (m_run + 1 == D) begin
                        m_fase = 2'd2; m_run = 0;
                        if ($countones(m_alvo) == 1) begin
                            m_jog = m_alvo; m_tem = 1'b1;
                        end else begin
                            m_inv = 1'b1;
                        end
                    end else begin
                        m_run = m_run + 1;
                    end
                end
                2'd2: if (visto == 4'b0000) begin
                    m_fase = 2'd3; m_run = 0;
                end
                default: begin
                    if (visto != 4'b0000) m_fase = 2'd2;
                    else if (m_run == D) m_fase = 2'd0;
                    else m_run = m_run + 1;
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; habilita = 1'b0; botoes = 4'b0000;
        tick();
        reset = 1'b0;
        checks++;
        if ({jogada, tem_jogada, invalida, db_estado} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got jogada=%b tem=%b inv=%b est=%0d expected all 0",
                     jogada, tem_jogada, invalida, db_estado);
        end
    endtask

    // Tick 0 is the first edge that samples the new button value.
    task automatic test_press_release();
        int n_puls = 0;
        int borda = -1;
        int borda_ocioso = -1;
        habilita = 1'b1; botoes = 4'b0100;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (tem_jogada) begin n_puls++; if (borda < 0) borda = n; end
        end
        checks++;
        if (n_puls != 1 || borda != D + 2) begin
            errors++;
            $display("FAIL press_latency: got %0d pulses first at %0d expected 1 at %0d", n_puls, borda, D + 2);
        end
        checks++;
        if (jogada !== 4'b0100) begin
            errors++;
            $display("FAIL press_jogada: got %b expected 0100", jogada);
        end
        botoes = 4'b0000;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (db_estado == 2'd0 && borda_ocioso < 0) borda_ocioso = n;
        end
        checks++;
        if (borda_ocioso != D + 3) begin
            errors++;
            $display("FAIL release_latency: got idle at %0d expected %0d", borda_ocioso, D + 3);
        end
    endtask

    task automatic test_bounce();
        int n_puls = 0;
        int borda = -1;
        botoes = 4'b0010;
        for (int n = 0; n < 5; n++) tick();
        botoes = 4'b0000;
        for (int n = 0; n < 3; n++) tick();
        botoes = 4'b0010;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (tem_jogada || invalida) begin n_puls++; if (borda < 0) borda = n; end
        end
        checks++;
        if (n_puls != 1 || borda != D + 2) begin
            errors++;
            $display("FAIL bounce_pulse: got %0d pulses first at %0d expected 1 at %0d", n_puls, borda, D + 2);
        end
        checks++;
        if (jogada !== 4'b0010) begin
            errors++;
            $display("FAIL bounce_jogada: got %b expected 0010", jogada);
        end
        botoes = 4'b0000;
        for (int n = 0; n < 30; n++) tick();
    endtask

    task automatic test_invalid();
        int n_inv = 0;
        int n_tem = 0;
        int borda = -1;
        botoes = 4'b0001;
        for (int n = 0; n < 30; n++) tick();
        botoes = 4'b0000;
        for (int n = 0; n < 30; n++) tick();
        botoes = 4'b0011;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (tem_jogada) n_tem++;
            if (invalida) begin n_inv++; if (borda < 0) borda = n; end
        end
        checks++;
        if (n_inv != 1 || n_tem != 0 || borda != D + 2) begin
            errors++;
            $display("FAIL invalid_chord: got inv=%0d tem=%0d at %0d expected inv=1 tem=0 at %0d",
                     n_inv, n_tem, borda, D + 2);
        end
        checks++;
        if (jogada !== 4'b0001) begin
            errors++;
            $display("FAIL invalid_keeps_jogada: got %b expected 0001", jogada);
        end
        botoes = 4'b0000;
        for (int n = 0; n < 30; n++) tick();
    endtask

    task automatic test_habilita();
        int n_puls = 0;
        int borda = -1;
        habilita = 1'b0; botoes = 4'b1000;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (tem_jogada || invalida) n_puls++;
        end
        checks++;
        if (n_puls != 0 || db_estado !== 2'd0) begin
            errors++;
            $display("FAIL disabled_no_pulse: got %0d pulses est=%0d expected 0 pulses est=0", n_puls, db_estado);
        end
        // Tick 0 is one edge after the drive edge, so D here is D+1 edges after it.
        habilita = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (tem_jogada && borda < 0) borda = n;
        end
        checks++;
        if (borda != D || jogada !== 4'b1000) begin
            errors++;
            $display("FAIL enable_held: got pulse at %0d jogada=%b expected %0d jogada=1000", borda, jogada, D);
        end
        botoes = 4'b0000;
        for (int n = 0; n < 30; n++) tick();
    endtask

    task automatic test_reset_mid_press();
        int n_puls = 0;
        int borda = -1;
        botoes = 4'b0001;
        for (int n = 0; n < 10; n++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({jogada, tem_jogada, invalida, db_estado} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_press: got jogada=%b tem=%b inv=%b est=%0d expected all 0",
                     jogada, tem_jogada, invalida, db_estado);
        end
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (tem_jogada) begin n_puls++; if (borda < 0) borda = n; end
        end
        checks++;
        if (n_puls != 1 || borda != D + 2 || jogada !== 4'b0001) begin
            errors++;
            $display("FAIL after_reset_press: got %0d pulses at %0d jogada=%b expected 1 at %0d jogada=0001",
                     n_puls, borda, jogada, D + 2);
        end
        botoes = 4'b0000;
        for (int n = 0; n < 30; n++) tick();
    endtask

    task automatic test_random();
        int   sorteio;
        int   duracao;
        logic pulso_ant = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            sorteio = $urandom_range(0, 9);
            if (sorteio < 3)      botoes = 4'b0000;
            else if (sorteio < 8) botoes = 4'b0001 << $urandom_range(0, 3);
            else                  botoes = 4'($urandom_range(0, 15));
            habilita = ($urandom_range(0, 7) != 0);
            duracao = $urandom_range(1, 40);
            for (int c = 0; c < duracao; c++) begin
                tick();
                checks++;
                if (jogada !== m_jog) begin
                    errors++;
                    $display("FAIL rand_jogada: got %b expected %b", jogada, m_jog);
                end
                checks++;
                if (tem_jogada !== m_tem || invalida !== m_inv) begin
                    errors++;
                    $display("FAIL rand_pulses: got tem=%b inv=%b expected tem=%b inv=%b",
                             tem_jogada, invalida, m_tem, m_inv);
                end
                checks++;
                if (db_estado !== m_fase) begin
                    errors++;
                    $display("FAIL rand_estado: got %0d expected %0d", db_estado, m_fase);
                end
                checks++;
                if ((tem_jogada && invalida) || (pulso_ant && (tem_jogada || invalida))) begin
                    errors++;
                    $display("FAIL pulse_exclusive: got tem=%b inv=%b prev=%b expected isolated single pulse",
                             tem_jogada, invalida, pulso_ant);
                end
                pulso_ant = tem_jogada || invalida;
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_invalid();
        test_habilita();
        test_reset_mid_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
